// File: rtl/div_ratio_ctrl.sv
// Ratio/enable controller for the clock divider: gates the divider, waits a settle window,
// loads the new ratio, re-enables. Optional input clamp enabled by defining DIV_RATIO_CLAMP_EN.
module div_ratio_ctrl #(
    parameter int unsigned RATIO_WD    = 4,
    parameter int unsigned RESET_RATIO = 2,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned MIN_RATIO   = 2
) (
    input  logic                I_ref_clk,
    input  logic                I_rst_n,
    input  logic                I_run,
    input  logic                I_req,
    input  logic [RATIO_WD-1:0] I_new_ratio,
    output logic [RATIO_WD-1:0] O_div_ratio,
    output logic                O_clk_en,
    output logic                O_ack,
    output logic                O_busy,
    output logic                O_bypass
);

    localparam logic [RATIO_WD-1:0] LP_RESET_RATIO = RATIO_WD'(RESET_RATIO);
    localparam logic [RATIO_WD-1:0] LP_MIN_RATIO   = RATIO_WD'(MIN_RATIO);
    localparam logic [RATIO_WD-1:0] LP_ONE         = RATIO_WD'(1);
    localparam logic [7:0]          LP_SETTLE_LAST = 8'(SETTLE_CYC - 1);
`ifdef DIV_RATIO_CLAMP_EN
    localparam bit                  LP_CLAMP_EN    = 1'b1;
`else
    localparam bit                  LP_CLAMP_EN    = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic [RATIO_WD-1:0] r_shadow;
    logic [RATIO_WD-1:0] w_shadow_nxt;
    logic [RATIO_WD-1:0] r_ratio;
    logic [RATIO_WD-1:0] w_ratio_nxt;
    logic                r_clk_en;
    logic                w_clk_en_nxt;
    logic                r_ack;
    logic                w_ack_nxt;
    logic [RATIO_WD-1:0] w_req_ratio;

    always_comb begin
        w_req_ratio = I_new_ratio;
        if (LP_CLAMP_EN && (I_new_ratio < LP_MIN_RATIO)) begin
            w_req_ratio = LP_MIN_RATIO;
        end
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= LP_RESET_RATIO;
            r_ratio  <= LP_RESET_RATIO;
            r_clk_en <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_ratio  <= w_ratio_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_ratio_nxt  = r_ratio;
        w_clk_en_nxt = r_clk_en;
        w_ack_nxt    = r_ack;
        unique case (r_state)
            ST_IDLE: begin
                w_clk_en_nxt = I_run;
                w_ack_nxt    = 1'b0;
                if (I_req) begin
                    if (w_req_ratio == r_ratio) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_shadow_nxt = w_req_ratio;
                        w_clk_en_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                w_clk_en_nxt = 1'b0;
                if (r_cnt == LP_SETTLE_LAST) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_LOAD: begin
                w_clk_en_nxt = 1'b0;
                w_ratio_nxt  = r_shadow;
                w_state_nxt  = ST_DONE;
            end
            ST_DONE: begin
                // Ack is raised for at least one cycle before a low I_req can retire it,
                // so a request dropped early still produces a single-cycle ack pulse.
                w_clk_en_nxt = I_run;
                if (!r_ack) begin
                    w_ack_nxt = 1'b1;
                end else if (!I_req) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign O_div_ratio = r_ratio;
    assign O_clk_en    = r_clk_en;
    assign O_ack       = r_ack;
    assign O_busy      = (r_state != ST_IDLE);
    assign O_bypass    = (r_ratio <= LP_ONE);

endmodule

// File: doc/div_ratio_ctrl.md
Name: div_ratio_ctrl

Overview:
- Upstream companion of the parameterized clock divider, in the I_ref_clk domain.
- Owns the divider's ratio and enable inputs (O_div_ratio -> I_div_ratio, O_clk_en -> I_clk_en).
- Applies software ratio changes glitch-safely: gates the divider, holds for a settle window, loads the new ratio, then re-enables.
- Four-phase req/ack handshake toward the register/config logic.

Parameters:
- RATIO_WD, 4: width of the ratio bus; must match the divider.
- RESET_RATIO, 2: O_div_ratio value after reset.
- SETTLE_CYC, 2: I_ref_clk cycles O_clk_en is held low before the load; legal 1..255 (8-bit internal counter).
- MIN_RATIO, 2: clamp floor; used only with DIV_RATIO_CLAMP_EN.

Ports:
- I_ref_clk  in  1  reference clock; all logic on rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_run  in  1  software run enable for the divided clock.
- I_req  in  1  ratio change request; held high until O_ack is seen.
- I_new_ratio  in  RATIO_WD  requested ratio; sampled when I_req is accepted.
- O_div_ratio  out  RATIO_WD  ratio to the divider (registered).
- O_clk_en  out  1  enable to the divider (registered).
- O_ack  out  1  request done; high until I_req falls.
- O_busy  out  1  high in any state other than IDLE.
- O_bypass  out  1  combinational, (O_div_ratio <= 1); divider passes I_ref_clk through.

Behaviour:
- Reset values: O_div_ratio=RESET_RATIO, O_clk_en=0, O_ack=0, state=IDLE, counter=0.
- O_busy=0 in IDLE. O_bypass follows from O_div_ratio.
- FSM states: IDLE, GATE, LOAD, DONE. All outputs are registered except O_bypass and O_busy (decoded from state).
- IDLE:
  - O_clk_en <= I_run every cycle (one-cycle latency).
  - I_req=1 and I_new_ratio==O_div_ratio: shadow not needed; go to DONE. O_clk_en keeps tracking I_run; no gating.
  - I_req=1 and ratio differs: shadow <= I_new_ratio, O_clk_en <= 0, counter <= 0, go to GATE.
- GATE:
  - O_clk_en stays 0 regardless of I_run.
  - Counter increments each cycle; at counter==SETTLE_CYC-1, go to LOAD.
  - GATE lasts exactly SETTLE_CYC cycles.
- LOAD (one cycle): O_div_ratio <= shadow; go to DONE.
- DONE:
  - O_ack=1, O_clk_en <= I_run.
  - When I_req=0: O_ack <= 0, go to IDLE.
- Timing: req accepted at edge k -> O_clk_en=0 after edge k -> O_div_ratio new after edge k+SETTLE_CYC+1 -> O_ack=1 and O_clk_en=I_run after edge k+SETTLE_CYC+2.
- Equal-ratio shortcut: O_ack=1 after edge k+1; O_clk_en is never dropped.
- Ratio 0 or 1: loaded verbatim (without the macro); O_bypass=1 after the load.
- I_new_ratio changes after acceptance: ignored; the shadow holds the accepted value.
- I_req drops before ack (protocol violation): the sequence still completes. DONE sees I_req=0, so O_ack is high for one cycle, then IDLE.
- I_run toggles during GATE/LOAD: no effect on O_clk_en; the new value takes effect from DONE.
- Reset mid-sequence: immediate return to reset values; O_div_ratio=RESET_RATIO, not the shadow.
- O_div_ratio changes only in LOAD, and LOAD is only reached with O_clk_en=0.

Optional Feature:
- DIV_RATIO_CLAMP_EN defined: when captured into the shadow, I_new_ratio < MIN_RATIO is replaced by MIN_RATIO.
  - The equal-ratio comparison uses the clamped value.
  - O_bypass can only go high if RESET_RATIO <= 1.
- Not defined: ratio is taken verbatim; MIN_RATIO is unused.

Test Plan:
- Reset, I_run=1: O_div_ratio=2, O_clk_en=0; O_clk_en=1 one cycle after reset release; O_busy=0, O_ack=0.
- Change 2 -> 6, SETTLE_CYC=2, I_req held, accepted at edge k:
  - O_clk_en=0 for edges k..k+3.
  - O_div_ratio=6 after edge k+3.
  - O_ack=1 and O_clk_en=1 after edge k+4.
  - After I_req drops: O_ack=0 next edge, state IDLE.
- Request with I_new_ratio=2 while ratio=2: O_clk_en stays 1 throughout; O_ack=1 one cycle after acceptance.
- I_new_ratio=1: O_bypass=1 after the load; with DIV_RATIO_CLAMP_EN, O_div_ratio=2 and O_bypass=0.
- Pulse I_req for one cycle with ratio 3:
  - Full sequence completes; O_div_ratio=3.
  - O_ack is a single-cycle pulse, then IDLE.
- Assert I_rst_n=0 during GATE: O_clk_en=0, O_div_ratio=2, O_ack=0 immediately, without waiting for a clock edge.
